// File: rtl/axis_cpu_datapath_p_pkg.sv
// Shared select encodings for the axis_cpu controller and datapath.
package axis_cpu_datapath_p_pkg;

   localparam logic [2:0] A_SEL_IMM    = 3'd0;
   localparam logic [2:0] A_SEL_MEM    = 3'd1;
   localparam logic [2:0] A_SEL_ALU    = 3'd2;
   localparam logic [2:0] A_SEL_X      = 3'd3;

   localparam logic [2:0] X_SEL_IMM    = 3'd0;
   localparam logic [2:0] X_SEL_MEM    = 3'd1;
   localparam logic [2:0] X_SEL_STREAM = 3'd2;
   localparam logic [2:0] X_SEL_A      = 3'd3;

   localparam logic [1:0] PC_SEL_PLUS_1   = 2'd0;
   localparam logic [1:0] PC_SEL_PLUS_IMM = 2'd1;
   localparam logic [1:0] PC_SEL_PLUS_JMP = 2'd2;
   localparam logic [1:0] PC_SEL_HOLD     = 2'd3;

   localparam logic ALU_B_SEL_IMM = 1'b0;
   localparam logic ALU_B_SEL_X   = 1'b1;

   localparam logic REGFILE_IN_A = 1'b0;
   localparam logic REGFILE_IN_X = 1'b1;

endpackage

// File: rtl/axis_cpu_out_reg.sv
// One-entry AXI-Stream holding register; full flags a beat stalled by backpressure.
module axis_cpu_out_reg #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          push_last,
   output logic          full,
   output logic [DW-1:0] tdata,
   output logic          tvalid,
   output logic          tlast,
   input  logic          tready
);

   logic [DW-1:0] data_r;
   logic          valid_r;
   logic          last_r;
   logic          full_s;

   assign full_s = valid_r & ~tready;

   // Capture on push when not stalled (covers same-cycle drain and refill), else drain on handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r  <= {DW{1'b0}};
         valid_r <= 1'b0;
         last_r  <= 1'b0;
      end else if (push && !full_s) begin
         data_r  <= push_data;
         valid_r <= 1'b1;
         last_r  <= push_last;
      end else if (tready) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign full   = full_s;
   assign tdata  = data_r;
   assign tvalid = valid_r;
   assign tlast  = last_r;

endmodule

// File: rtl/sdp_lut_ram.sv
// Simple dual-port LUT RAM: synchronous write, asynchronous read, no reset.
module sdp_lut_ram #(
   parameter int AW = 4,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem_r [2**AW];

   // Write port
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/axis_cpu_datapath_p.sv
// Parametrised AXI-Stream CPU datapath: A/X/PC registers, regfile, imm/jump tables, stream ports.
module axis_cpu_datapath_p
   import axis_cpu_datapath_p_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int CODE_ADDR_WIDTH = 10,
   parameter int REGFILE_AW      = 4,
   parameter int TABLE_AW        = 4,
   parameter int JMP_OFF_WIDTH   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [2:0]                 A_sel,
   input  logic                       A_en,
   input  logic [2:0]                 X_sel,
   input  logic                       X_en,
   input  logic [1:0]                 PC_sel,
   input  logic                       PC_en,
   output logic [CODE_ADDR_WIDTH-1:0] pc,
   input  logic [CODE_ADDR_WIDTH-1:0] jmp_correction,
   input  logic                       B_sel,
   output logic [DATA_WIDTH-1:0]      alu_a,
   output logic [DATA_WIDTH-1:0]      alu_b,
   input  logic [DATA_WIDTH-1:0]      alu_out,
   input  logic [TABLE_AW-1:0]        utility_addr,
   input  logic                       imm_sel_en,
   input  logic                       jmp_sel_en,
   input  logic [REGFILE_AW-1:0]      regfile_addr,
   input  logic                       regfile_sel,
   input  logic                       regfile_wr_en,
   input  logic                       imm_wr_en,
   input  logic [TABLE_AW-1:0]        imm_wr_addr,
   input  logic [DATA_WIDTH-1:0]      imm_wr_data,
   input  logic                       jmp_wr_en,
   input  logic [TABLE_AW-1:0]        jmp_wr_addr,
   input  logic [JMP_OFF_WIDTH-1:0]   jmp_wr_data,
   input  logic [DATA_WIDTH-1:0]      din_TDATA,
   input  logic                       din_TVALID,
   input  logic                       din_TLAST,
   output logic                       din_TREADY,
   input  logic                       din_consume,
   output logic                       last,
   input  logic                       out_push,
   input  logic                       out_last,
   output logic                       out_full,
   output logic [DATA_WIDTH-1:0]      dout_TDATA,
   output logic                       dout_TVALID,
   output logic                       dout_TLAST,
   input  logic                       dout_TREADY
);

   localparam int DW  = DATA_WIDTH;
   localparam int CAW = CODE_ADDR_WIDTH;
   localparam int JOW = JMP_OFF_WIDTH;

   logic [DW-1:0]       a_r, x_r;
   logic [CAW-1:0]      pc_r, pc_next_s;
   logic                last_r;
   logic [TABLE_AW-1:0] imm_sel_r, jmp_sel_r;
   logic [DW-1:0]       imm_data_s, rf_rd_s, src_sel_s;
   logic [JOW-1:0]      jmp_off_s;
   logic [CAW-1:0]      jmp_ext_s;

   generate
      if (JOW < CAW) begin : g_sext
         assign jmp_ext_s = {{(CAW-JOW){jmp_off_s[JOW-1]}}, jmp_off_s};
      end else begin : g_trunc
         assign jmp_ext_s = jmp_off_s[CAW-1:0];
      end
   endgenerate

   assign src_sel_s = (regfile_sel == REGFILE_IN_X) ? x_r : a_r;

   sdp_lut_ram #(.AW(REGFILE_AW), .DW(DW)) u_regfile (
      .clk(clk), .wr_en(regfile_wr_en), .wr_addr(regfile_addr), .wr_data(src_sel_s),
      .rd_addr(regfile_addr), .rd_data(rf_rd_s));

   sdp_lut_ram #(.AW(TABLE_AW), .DW(DW)) u_imm_tbl (
      .clk(clk), .wr_en(imm_wr_en), .wr_addr(imm_wr_addr), .wr_data(imm_wr_data),
      .rd_addr(imm_sel_r), .rd_data(imm_data_s));

   sdp_lut_ram #(.AW(TABLE_AW), .DW(JOW)) u_jmp_tbl (
      .clk(clk), .wr_en(jmp_wr_en), .wr_addr(jmp_wr_addr), .wr_data(jmp_wr_data),
      .rd_addr(jmp_sel_r), .rd_data(jmp_off_s));

   // A accumulator load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r <= {DW{1'b0}};
      end else if (A_en) begin
         case (A_sel)
            A_SEL_IMM: a_r <= imm_data_s;
            A_SEL_MEM: a_r <= rf_rd_s;
            A_SEL_ALU: a_r <= alu_out;
            A_SEL_X:   a_r <= x_r;
            default:   a_r <= a_r;
         endcase
      end else begin
         a_r <= a_r;
      end
   end

   // X index register load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_r <= {DW{1'b0}};
      end else if (X_en) begin
         case (X_sel)
            X_SEL_IMM:    x_r <= imm_data_s;
            X_SEL_MEM:    x_r <= rf_rd_s;
            X_SEL_STREAM: x_r <= din_TDATA;
            X_SEL_A:      x_r <= a_r;
            default:      x_r <= x_r;
         endcase
      end else begin
         x_r <= x_r;
      end
   end

   // TLAST of each consumed input beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_r <= 1'b0;
      end else if (din_consume && din_TVALID) begin
         last_r <= din_TLAST;
      end else begin
         last_r <= last_r;
      end
   end

   // Next PC; jump forms undo the controller's fetch-ahead via jmp_correction
   always_comb begin
      pc_next_s = pc_r;
      case (PC_sel)
         PC_SEL_PLUS_1:   pc_next_s = pc_r + CAW'(1);
         PC_SEL_PLUS_IMM: pc_next_s = pc_r + imm_data_s[CAW-1:0] - jmp_correction;
         PC_SEL_PLUS_JMP: pc_next_s = pc_r + jmp_ext_s - jmp_correction;
         PC_SEL_HOLD:     pc_next_s = pc_r;
         default:         pc_next_s = pc_r;
      endcase
   end

   // PC register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r <= {CAW{1'b0}};
      end else if (PC_en) begin
         pc_r <= pc_next_s;
      end else begin
         pc_r <= pc_r;
      end
   end

   // Table select registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         imm_sel_r <= {TABLE_AW{1'b0}};
         jmp_sel_r <= {TABLE_AW{1'b0}};
      end else begin
         imm_sel_r <= imm_sel_en ? utility_addr : imm_sel_r;
         jmp_sel_r <= jmp_sel_en ? utility_addr : jmp_sel_r;
      end
   end

   axis_cpu_out_reg #(.DW(DW)) u_out_reg (
      .clk(clk), .rst(rst), .push(out_push), .push_data(src_sel_s), .push_last(out_last),
      .full(out_full), .tdata(dout_TDATA), .tvalid(dout_TVALID), .tlast(dout_TLAST),
      .tready(dout_TREADY));

   assign pc         = pc_r;
   assign alu_a      = a_r;
   assign alu_b      = (B_sel == ALU_B_SEL_X) ? x_r : imm_data_s;
   assign last       = last_r;
   assign din_TREADY = din_consume;

endmodule
